// File: rtl/fir_pkg.sv
// Shared types, default coefficient set and sizing helpers for the folded FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} fir_state_t;

  // Half of the symmetric 31-tap low-pass kernel, k = 0 (outermost) .. 15 (centre).
  localparam int DEFAULT_COEFS [16] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};

  function automatic logic [7:0] default_coef(input int k);
    if (k >= 0 && k < 16) return 8'(DEFAULT_COEFS[k]);
    return 8'd0;
  endfunction

  // Sum of HALF products of (DW+1)-bit pairs and CW-bit coefficients.
  function automatic int acc_width(input int dw, input int cw, input int half);
    return dw + 1 + cw + $clog2(half);
  endfunction

endpackage

// File: rtl/fir_coef_regs.sv
// Run-time writable coefficient bank; writes are taken only while the filter is idle.
module fir_coef_regs
  import fir_pkg::*;
#(
  parameter int HALF = 16,
  parameter int CW   = 8,
  parameter int AW   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      idle,
  input  logic                      coef_we,
  input  logic [AW-1:0]             coef_addr,
  input  logic [CW-1:0]             coef_data,
  output logic [HALF-1:0][CW-1:0]   coef,
  output logic                      coef_ack
);

  logic wr_ok;

  assign wr_ok = coef_we && idle && (32'(coef_addr) < 32'(HALF));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HALF; i++) coef[i] <= CW'(default_coef(i));
      coef_ack <= 1'b0;
    end else begin
      if (wr_ok) coef[coef_addr] <= coef_data;
      coef_ack <= wr_ok;
    end
  end

endmodule

// File: rtl/fir_mac_filter.sv
// Symmetric FIR low-pass: delay line, folded pairs, one shared multiplier, round and saturate.
module fir_mac_filter
  import fir_pkg::*;
#(
  parameter  int DW    = 10,
  parameter  int NTAPS = 31,
  parameter  int CW    = 8,
  parameter  int SHIFT = 10,
  localparam int HALF  = (NTAPS + 1) / 2,
  localparam int KW    = $clog2(HALF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sample,
  output logic          out_valid,
  output logic [DW-1:0] out_sample,
  input  logic          coef_we,
  input  logic [KW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          coef_ack,
  output logic          overrun,
  input  logic          overrun_clr
);

  localparam int AW = acc_width(DW, CW, HALF);
  localparam int PW = DW + 1 + CW;
  localparam logic [AW:0] RND  = (AW+1)'(1) << (SHIFT - 1);
  localparam logic [AW:0] MAXV = (AW+1)'((1 << DW) - 1);

  fir_state_t              state, state_next;
  logic [KW-1:0]           k;
  logic [DW-1:0]           v [NTAPS];
  logic [DW:0]             pair [HALF];
  logic [HALF-1:0][CW-1:0] coef;
  logic [AW-1:0]           acc;
  logic [PW-1:0]           prod;
  logic [AW:0]             rounded;
  logic [DW-1:0]           result;
  logic                    accept, drop;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && (state == IDLE);
  assign drop     = in_valid && (state != IDLE);

  fir_coef_regs #(.HALF(HALF), .CW(CW), .AW(KW)) u_coef (
    .clk       (clk),
    .reset     (reset),
    .idle      (state == IDLE),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef      (coef),
    .coef_ack  (coef_ack)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_next;
      k     <= (state == ACCUM) ? k + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ACCUM;
      ACCUM:   if (k == KW'(HALF - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) v[i] <= '0;
    end else if (accept) begin
      v[0] <= in_sample;
      for (int i = 1; i < NTAPS; i++) v[i] <= v[i-1];
    end
  end

  // Mirror taps share a coefficient, so fold them before the multiplier.
  for (genvar gi = 0; gi < HALF - 1; gi++) begin : g_fold
    assign pair[gi] = {1'b0, v[gi]} + {1'b0, v[NTAPS-1-gi]};
  end
  assign pair[HALF-1] = {1'b0, v[HALF-1]};

  assign prod = {{(DW+1){1'b0}}, coef[k]} * {{CW{1'b0}}, pair[k]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               acc <= '0;
    else if (accept)         acc <= '0;
    else if (state == ACCUM) acc <= acc + AW'(prod);
  end

  assign rounded = ({1'b0, acc} + RND) >> SHIFT;
  assign result  = (rounded > MAXV) ? {DW{1'b1}} : rounded[DW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      out_valid <= (state == DONE);
      if (state == DONE) out_sample <= result;
    end
  end

  // A drop in the same cycle as a clear must still be reported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

endmodule

// File: doc/fir_mac_filter.md
# fir_mac_filter

Parametrised symmetric FIR low-pass filter for the heart-rate front end. It sits between the SPI sample capture and the peak detector, and replaces the fixed 31-tap fully-parallel filter. It computes one output per accepted sample with a single time-shared multiplier over the folded (symmetric) tap pairs. It adds a valid/ready handshake, run-time writable coefficients, rounding, saturation and overrun reporting.

## Interface
- DW, 10: sample and output width, unsigned.
- NTAPS, 31: tap count; must be odd and ≥3.
- CW, 8: coefficient width, unsigned.
- SHIFT, 10: output right-shift (coefficient scale is 2^SHIFT).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  sample strobe.
- in_ready  out  1  high when a sample can be accepted.
- in_sample  in  DW  raw sample.
- out_valid  out  1  one-cycle pulse, filtered result valid.
- out_sample  out  DW  filtered, rounded, saturated result.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(HALF)  pair index k, with HALF=(NTAPS+1)/2.
- coef_data  in  CW  coefficient value.
- coef_ack  out  1  one-cycle pulse, write accepted.
- overrun  out  1  sticky flag: a sample was dropped.
- overrun_clr  in  1  clears overrun.

## Operation
- Delay line v[0..NTAPS-1]: v[0] is the newest sample. On accept, the line shifts and in_sample is loaded into v[0].
- Pair term k, for k<HALF-1: v[k]+v[NTAPS-1-k], width DW+1. The centre term k=HALF-1 is v[HALF-1] alone.
- Result: acc = Σ c[k]·pair[k], accumulated one k per cycle in ascending k.
- Accumulator width: DW+1+CW+$clog2(HALF). It cannot overflow.
- out = (acc + 2^(SHIFT-1)) >> SHIFT, i.e. round half up. If the result exceeds 2^DW−1, it saturates to 2^DW−1.
- FSM states:
  - IDLE → ACCUM on in_valid (the sample is accepted).
  - ACCUM runs HALF cycles (k = 0..HALF-1), then → DONE.
  - DONE drives out_valid for 1 cycle, then → IDLE.
- in_ready = (state==IDLE).
- in_valid while in_ready is low: the sample is dropped and overrun is set. The delay line and the computation in progress are unaffected.
- If set and clear happen in the same cycle, set wins.
- Coefficients: register bank c[0..HALF-1]. Reset values come from the package default, and a write is accepted only in IDLE.
  - Accepted write: c[coef_addr] is updated, and coef_ack pulses on the next cycle.
  - coef_we outside IDLE: ignored, no ack.
  - coef_we and in_valid in the same IDLE cycle: both are accepted, and the computation uses the new coefficient.
  - coef_addr ≥ HALF: ignored, no ack.
- Reset values:
  - delay line: all 0
  - state: IDLE
  - in_ready: 1
  - out_valid: 0
  - out_sample: 0
  - coef_ack: 0
  - overrun: 0
  - accumulator: 0
- Reset mid-ACCUM aborts the computation with no out_valid pulse. Coefficients return to their defaults.

## Timing
- A sample accepted at edge T produces out_valid high in the cycle following edge T+HALF+1. Latency is HALF+1 cycles; with the defaults this is 17.
- Maximum sustained rate is one sample per HALF+2 cycles. The SPI frame of 32 sck at 1 sample/frame is well within this.
- out_sample holds its value until the next out_valid.
- The accumulator clears on accept.
- All registers are on clk, with no other clock domains. The sample source synchronises its strobe into clk upstream.

## Structure
- Package fir_pkg holds:
  - the state enum (IDLE, ACCUM, DONE);
  - DEFAULT_COEFS for the 31-tap set, k=0..15: 3,4,6,8,12,17,23,29,36,43,50,56,61,65,67,68;
  - a function giving the accumulator width.
- Sub-module fir_coef_regs: the coefficient bank with write qualification and the ack pulse.
- Top-level holds the delay line, FSM, MAC datapath and output stage.

## Test plan
- DC 512 held for 40 samples, default coefficients (Σ=1028) → steady out_sample 514; each out_valid arrives 17 cycles after its accept.
- DC 1023 → 1023·1028/1024 exceeds full scale → out_sample saturates at 1023.
- Impulse 1000 then zeros → first output 3, 16th output 66 (centre), 31st output 3, then 0.
- Write c[15]=0 in IDLE (coef_ack pulses next cycle), then DC 512 → steady output 480. A second write issued during ACCUM gets no ack, and the coefficient is unchanged.
- in_valid on every cycle → exactly one accept per 18 cycles, and overrun sets. overrun_clr asserted together with a drop leaves overrun at 1.
- Reset asserted at ACCUM k=8 → no out_valid, in_ready=1, outputs 0; the next impulse reproduces the expected response from the start.
